// File: rtl/mem_frame_arbiter.sv
// Merges the AXI write-frame and read-frame streams into one registered frame stream.
// Round-robin at frame granularity; a grant stays locked from first beat to eof.
module mem_frame_arbiter #(
    parameter int FRAME_WIDTH = 97,
    parameter int SOF_BIT     = 87,
    parameter int EOF_BIT     = 88,
    parameter int RW_BIT      = 86
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   axi2arb_wframe_valid,
    output logic                   axi2arb_wframe_ready,
    input  logic [FRAME_WIDTH-1:0] axi2arb_wframe_data,
    input  logic                   axi2arb_rframe_valid,
    output logic                   axi2arb_rframe_ready,
    input  logic [FRAME_WIDTH-1:0] axi2arb_rframe_data,
    output logic                   arb2array_frame_valid,
    input  logic                   arb2array_frame_ready,
    output logic [FRAME_WIDTH-1:0] arb2array_frame_data,
    output logic                   arb_busy,
    output logic                   arb_sof_err
);

    typedef enum logic [1:0] {IDLE, GNT_W, GNT_R} state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic                   r_rr_pri;
    logic                   r_out_valid;
    logic [FRAME_WIDTH-1:0] r_out_data;
    logic [10:0]            r_beat_cnt;
    logic                   r_sof_err;

    logic                   w_grant_w;
    logic                   w_grant_r;
    logic                   w_out_ready_int;
    logic                   w_accept;
    logic [FRAME_WIDTH-1:0] w_in_data;
    logic                   w_eof;
    logic                   w_sof;

    // In IDLE the grant is combinational so a waiting source is taken the same cycle.
    always_comb begin
        w_grant_w = 1'b0;
        w_grant_r = 1'b0;
        case (r_state)
            IDLE: begin
                if (axi2arb_wframe_valid && (!axi2arb_rframe_valid || !r_rr_pri))
                    w_grant_w = 1'b1;
                else if (axi2arb_rframe_valid)
                    w_grant_r = 1'b1;
            end
            GNT_W:   w_grant_w = 1'b1;
            GNT_R:   w_grant_r = 1'b1;
            default: ;
        endcase
    end

    assign w_out_ready_int = ~r_out_valid | arb2array_frame_ready;
    assign w_in_data       = w_grant_r ? axi2arb_rframe_data : axi2arb_wframe_data;
    assign w_eof           = w_in_data[EOF_BIT];
    assign w_sof           = w_in_data[SOF_BIT];
    assign w_accept        = ((w_grant_w & axi2arb_wframe_valid) |
                              (w_grant_r & axi2arb_rframe_valid)) & w_out_ready_int;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept && !w_eof)
                    w_state_nxt = w_grant_w ? GNT_W : GNT_R;
            end
            GNT_W, GNT_R: begin
                if (w_accept && w_eof)
                    w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_rr_pri    <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_beat_cnt  <= '0;
            r_sof_err   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_sof_err <= w_accept && (r_state != IDLE) && w_sof && (r_beat_cnt != 11'd0);
            if (w_out_ready_int) begin
                r_out_valid <= w_accept;
                if (w_accept)
                    r_out_data <= w_in_data;
            end
            if (w_accept) begin
                r_beat_cnt <= w_eof ? 11'd0 : r_beat_cnt + 11'd1;
                // Frame done: hand priority to the source that was not just served.
                if (w_eof)
                    r_rr_pri <= w_grant_w;
            end
        end
    end

    // Readies are combinational, so gate them off while reset is held.
    assign axi2arb_wframe_ready  = w_grant_w & w_out_ready_int & ~rst;
    assign axi2arb_rframe_ready  = w_grant_r & w_out_ready_int & ~rst;
    assign arb2array_frame_valid = r_out_valid;
    assign arb2array_frame_data  = r_out_data;
    assign arb_busy              = (r_state != IDLE);
    assign arb_sof_err           = r_sof_err;

endmodule

// File: tb/tb_mem_frame_arbiter.sv
// Directed bench for mem_frame_arbiter: scoreboard of accepted beats checked on the output.
module tb_mem_frame_arbiter;
    localparam int FW = 97;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wv = 1'b0, rv = 1'b0, oready = 1'b1;
    logic [FW-1:0] wdata = '0, rdata = '0;
    logic          wready, rready, ovalid, busy, sof_err;
    logic [FW-1:0] odata;

    mem_frame_arbiter dut (
        .clk(clk), .rst(rst),
        .axi2arb_wframe_valid(wv), .axi2arb_wframe_ready(wready), .axi2arb_wframe_data(wdata),
        .axi2arb_rframe_valid(rv), .axi2arb_rframe_ready(rready), .axi2arb_rframe_data(rdata),
        .arb2array_frame_valid(ovalid), .arb2array_frame_ready(oready),
        .arb2array_frame_data(odata), .arb_busy(busy), .arb_sof_err(sof_err)
    );

    always #5 clk = ~clk;

    typedef struct {logic [FW-1:0] d; int cyc;} exp_t;
    exp_t        sb[$];
    int          vectors = 0, miscompares = 0;
    int          cyc = 0, sof_cnt = 0, appear_cyc = 0;
    logic [31:0] order_code = 0;
    bit          prev_stall = 0;
    logic [FW-1:0] prev_data = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [FW-1:0] mk(input int len, input bit eof, input bit sof,
                                         input bit rw, input logic [21:0] addr);
        return {8'(len), eof, sof, rw, {$urandom, $urandom}, addr};
    endfunction

    // Output monitor: held beats must stay stable, each transfer pops the scoreboard.
    always @(negedge clk) begin : mon
        int   ap;
        exp_t e;
        if (rst) begin
            prev_stall <= 1'b0;
        end else begin
            if (sof_err) sof_cnt <= sof_cnt + 1;
            if (prev_stall) begin
                check("hold_valid", ovalid, 1);
                check("hold_data", odata, prev_data);
            end else if (ovalid) begin
                appear_cyc <= cyc;
            end
            ap = prev_stall ? appear_cyc : cyc;
            if (ovalid && oready) begin
                check("sb_underflow", sb.size() != 0, 1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check("beat_data", odata, e.d);
                    check("beat_latency", ap, e.cyc);
                end
            end
            prev_stall <= ovalid && !oready;
            prev_data  <= odata;
        end
    end

    // Drives one frame on a source; gap_at/gap_len insert a valid drop before that beat.
    task automatic send(input bit is_w, input int n, input logic [21:0] addr0, input int sof_at,
                        input int gap_at, input int gap_len, input bit expect_now);
        logic [FW-1:0] f;
        int            waited;
        for (int i = 0; i < n; i++) begin
            if (i == gap_at) begin
                if (is_w) wv = 1'b0; else rv = 1'b0;
                repeat (gap_len) begin
                    @(negedge clk);
                    check(is_w ? "rready_in_gap" : "wready_in_gap", is_w ? rready : wready, 0);
                end
                @(posedge clk); #1;
            end
            f = mk(n, i == n - 1, (i == 0) || (i == sof_at), is_w, addr0 + 22'(i));
            if (is_w) begin wv = 1'b1; wdata = f; end else begin rv = 1'b1; rdata = f; end
            waited = 0;
            forever begin
                @(negedge clk);
                if ((is_w ? wready : rready) || waited >= 200) break;
                waited++;
            end
            if (waited >= 200) begin
                check("ready_timeout", waited, 0);
                if (is_w) wv = 1'b0; else rv = 1'b0;
                return;
            end
            if (expect_now) check("ready_immediate", waited, 0);
            check("busy_at_beat", busy, i != 0);
            sb.push_back('{d: f, cyc: cyc + 1});
            order_code = {order_code[30:0], is_w};
            @(posedge clk); #1;
        end
        if (is_w) wv = 1'b0; else rv = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        int s0;

        // Reset state
        #2;
        check("rst_ovalid", ovalid, 0);
        check("rst_odata", odata, 0);
        check("rst_busy", busy, 0);
        check("rst_sof_err", sof_err, 0);
        check("rst_wready", wready, 0);
        check("rst_rready", rready, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        idle(1);

        // 4-beat read frame, downstream always ready
        order_code = 0;
        send(0, 4, 22'h10, -1, -1, 0, 1);
        idle(3);
        check("t1_busy_after", busy, 0);

        // Both sources valid together: write wins (rr_pri = 0), no interleave
        order_code = 0;
        fork
            send(1, 2, 22'h100, -1, -1, 0, 0);
            send(0, 2, 22'h200, -1, -1, 0, 0);
        join
        idle(3);
        check("t2_order", order_code[3:0], 4'b1100);

        // Priority back to write after the read frame
        order_code = 0;
        fork
            send(1, 1, 22'h120, -1, -1, 0, 0);
            send(0, 1, 22'h220, -1, -1, 0, 0);
        join
        idle(3);
        check("t2b_order", order_code[1:0], 2'b10);

        // Downstream stall for 3 cycles while beat 2 of a write frame is on the output
        fork
            send(1, 4, 22'h300, -1, -1, 0, 0);
            begin
                found = 0;
                for (int k = 0; k < 100; k++) begin
                    @(negedge clk);
                    if (ovalid && odata[21:0] == 22'h300) begin found = 1; break; end
                end
                check("t3_found_beat1", found, 1);
                @(posedge clk); #1;
                oready = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    check("t3_hold_addr", odata[21:0], 22'h301);
                    check("t3_wready_stall", wready, 0);
                end
                @(posedge clk); #1;
                oready = 1'b1;
            end
        join
        idle(3);

        // Locked read source drops valid mid-frame while write waits
        order_code = 0;
        fork
            send(0, 4, 22'h400, -1, 2, 2, 0);
            begin
                @(posedge clk); #1;
                send(1, 2, 22'h500, -1, -1, 0, 0);
            end
        join
        idle(3);
        check("t4_order", order_code[5:0], 6'b000011);
        check("t4_no_sof_err", sof_cnt, 0);

        // sof on beat 3 of a read frame
        s0 = sof_cnt;
        send(0, 4, 22'h600, 2, -1, 0, 0);
        idle(3);
        check("t5_sof_err_once", sof_cnt - s0, 1);
        check("t5_busy_after", busy, 0);

        // Single write frame sets rr_pri = 1, then reset lands mid-write-frame
        send(1, 1, 22'h6f0, -1, -1, 0, 0);
        idle(2);
        wv = 1'b1;
        for (int i = 0; i < 2; i++) begin
            wdata = mk(4, 0, i == 0, 1, 22'h700 + 22'(i));
            found = 0;
            for (int k = 0; k < 100; k++) begin
                @(negedge clk);
                if (wready) begin found = 1; break; end
            end
            check("t6_accept", found, 1);
            sb.push_back('{d: wdata, cyc: cyc + 1});
            @(posedge clk); #1;
        end
        rv = 1'b1;
        rdata = mk(1, 1, 1, 0, 22'h7ff);
        rst = 1'b1;
        #1;
        check("t6_rst_ovalid", ovalid, 0);
        check("t6_rst_odata", odata, 0);
        check("t6_rst_busy", busy, 0);
        check("t6_rst_wready", wready, 0);
        check("t6_rst_rready", rready, 0);
        check("t6_rst_sof_err", sof_err, 0);
        sb.delete();
        wv = 1'b0;
        rv = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        idle(1);

        // rr_pri cleared by reset: write first under contention
        order_code = 0;
        fork
            send(1, 1, 22'h900, -1, -1, 0, 0);
            send(0, 1, 22'ha00, -1, -1, 0, 0);
        join
        idle(3);
        check("t6_order", order_code[1:0], 2'b10);

        // Next read frame granted immediately from IDLE
        send(0, 2, 22'h800, -1, -1, 0, 1);
        idle(4);
        check("sb_drained", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
